// File: rtl/tftlcd_rx.sv
// tftlcd_rx: DE-mode parallel RGB receiver. It repacks each active pixel
// into a 24-bit word tagged with column, row, start-of-frame and end-of-line.
// It also measures the active geometry and flags lock loss or sync-while-DE
// protocol errors. Every frame-level event is resolved on the edge that
// loads the output stage of the input sample that caused it.
module tftlcd_rx #(
  parameter int MAX_H = 2048,
  parameter int MAX_V = 2048
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_HSYNC,
  input  logic        i_VSYNC,
  input  logic        i_DE,
  input  logic [7:0]  i_RED,
  input  logic [7:0]  i_GREEN,
  input  logic [7:0]  i_BLUE,
  output logic [23:0] o_pixel,
  output logic        o_valid,
  output logic [15:0] o_hpixel,
  output logic [15:0] o_vpixel,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_locked,
  output logic        o_err,
  output logic [15:0] o_line_len,
  output logic [15:0] o_frame_lines
);

  localparam logic [15:0] H_LAST = 16'(MAX_H - 1);
  localparam logic [15:0] V_LAST = 16'(MAX_V - 1);

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;   // {BLUE, GREEN, RED}
  } stage_t;

  typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

  stage_t      s1, s2;
  state_t      state;
  logic [15:0] col_cnt, row_cnt;
  logic [15:0] vs_lines;     // line count captured at the frame-closing vs_rise
  logic        vs_pend;      // vs_rise, delayed to the output-stage edge
  logic        prot_pend;    // sync-while-DE, delayed to the output-stage edge
  logic [15:0] ref_w;
  logic        have_ref;
  logic        mismatch;     // current frame cannot lock (width varied or tainted)

  logic        vs_rise, hs_rise, de_fall, violation, emit;
  logic [15:0] line_w, lines_now;

  assign vs_rise   = s1.vs & ~s2.vs;
  assign hs_rise   = s1.hs & ~s2.hs;
  assign de_fall   = s2.de & ~s1.de;
  assign violation = (vs_rise | hs_rise) & s1.de;
  assign line_w    = col_cnt + 16'd1;
  // A line that ends on the same edge as vs_rise still belongs to the closing frame.
  assign lines_now = (de_fall && row_cnt != V_LAST) ? row_cnt + 16'd1 : row_cnt;
  assign emit      = s2.de && (state != IDLE);

  // Two-deep input pipeline; s1 versus s2 gives the edge detectors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      // NOTE: non-blocking so s2 captures the old s1, forming a real shift register.
      s1 <= {i_HSYNC, i_VSYNC, i_DE, i_BLUE, i_GREEN, i_RED};
      s2 <= s1;
    end
  end

  // Column/row counters plus frame events pended for the output-stage edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      vs_lines  <= '0;
      vs_pend   <= 1'b0;
      prot_pend <= 1'b0;
    end else begin
      vs_pend   <= vs_rise;
      prot_pend <= violation;
      if (vs_rise) vs_lines <= lines_now;

      if (de_fall || hs_rise)
        col_cnt <= '0;
      else if (s2.de && col_cnt != H_LAST)
        col_cnt <= col_cnt + 16'd1;

      if (vs_rise)
        row_cnt <= '0;
      else if (de_fall && row_cnt != V_LAST)
        row_cnt <= row_cnt + 16'd1;
    end
  end

  // Output pixel and tags; they hold their last values on non-pixel cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: the pixel datapath is reset too, because every output must read 0 in reset.
      o_valid  <= 1'b0;
      o_pixel  <= '0;
      o_hpixel <= '0;
      o_vpixel <= '0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
    end else begin
      o_valid <= emit;
      if (emit) begin
        o_pixel  <= s2.rgb;
        o_hpixel <= col_cnt;
        o_vpixel <= row_cnt;
        o_sof    <= (col_cnt == '0) && (row_cnt == '0);
        o_eol    <= de_fall;
      end
    end
  end

  // Geometry lock FSM with registered lock/err/geometry outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      ref_w         <= '0;
      have_ref      <= 1'b0;
      mismatch      <= 1'b0;
      o_locked      <= 1'b0;
      o_err         <= 1'b0;
      o_line_len    <= '0;
      o_frame_lines <= '0;
    end else begin
      o_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (vs_pend) begin
            state    <= MEASURE;
            have_ref <= 1'b0;
            mismatch <= prot_pend;
          end
        end
        MEASURE: begin
          if (prot_pend) begin
            // Restart: the frame in progress can no longer be trusted.
            have_ref <= 1'b0;
            mismatch <= 1'b1;
          end else if (vs_pend) begin
            have_ref <= 1'b0;
            mismatch <= 1'b0;
            if (have_ref && !mismatch && vs_lines != '0) begin
              o_line_len    <= ref_w;
              o_frame_lines <= vs_lines;
              o_locked      <= 1'b1;
              state         <= LOCKED;
            end
          end else if (de_fall) begin
            if (!have_ref) begin
              ref_w    <= line_w;
              have_ref <= 1'b1;
            end else if (line_w != ref_w) begin
              mismatch <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (prot_pend || (de_fall && line_w != o_line_len)) begin
            // Mid-frame failure: the rest of this frame is not a valid measurement.
            o_err    <= 1'b1;
            o_locked <= 1'b0;
            have_ref <= 1'b0;
            mismatch <= 1'b1;
            state    <= MEASURE;
          end else if (vs_pend && vs_lines != o_frame_lines) begin
            // Frame boundary failure: the new frame starts a clean measurement.
            o_err    <= 1'b1;
            o_locked <= 1'b0;
            have_ref <= 1'b0;
            mismatch <= 1'b0;
            state    <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tftlcd_rx.sv
// Testbench for tftlcd_rx: a scoreboard of expected pixels is filled as
// stimulus is driven and drained by a monitor on the falling edge; each
// scenario task then checks lock, error and geometry outputs inline.
module tb_tftlcd_rx;

  localparam int HBP = 4;
  localparam int HFP = 2;
  localparam int W   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hsync = 1'b0, vsync = 1'b0, de = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic [23:0] o_pixel;
  logic        o_valid, o_sof, o_eol, o_locked, o_err;
  logic [15:0] o_hpixel, o_vpixel, o_line_len, o_frame_lines;

  tftlcd_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_HSYNC(hsync), .i_VSYNC(vsync), .i_DE(de),
    .i_RED(red), .i_GREEN(green), .i_BLUE(blue),
    .o_pixel(o_pixel), .o_valid(o_valid), .o_hpixel(o_hpixel), .o_vpixel(o_vpixel),
    .o_sof(o_sof), .o_eol(o_eol), .o_locked(o_locked), .o_err(o_err),
    .o_line_len(o_line_len), .o_frame_lines(o_frame_lines)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pix;
    logic [15:0] h;
    logic [15:0] v;
    logic        sof;
    logic        eol;
    int          smp;   // index of the rising edge that sampled the pixel
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          passed = 0, total = 0;
  int          cyc = 0;
  logic        emit_model = 1'b0;
  int          row_m = 0;
  int          last_vs_smp = 0;
  logic        force_first = 1'b0;
  int          valid_cnt = 0, sof_cnt = 0, eol_cnt = 0, err_cnt = 0;
  int          last_err_cyc = -1, sof_lat = -1;
  logic        err_eol = 1'b0;
  logic [15:0] err_h = '0;
  logic [23:0] sof_pix = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      valid_cnt++;
      if (o_sof) sof_cnt++;
      if (o_eol) eol_cnt++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_valid: pixel %h at h=%0d v=%0d, none expected", o_pixel, o_hpixel, o_vpixel);
      end else begin
        e = sb.pop_front();
        if (o_sof) begin
          sof_pix = o_pixel;
          sof_lat = cyc - e.smp;
        end
        if ({o_pixel, o_hpixel, o_vpixel, o_sof, o_eol} !== {e.pix, e.h, e.v, e.sof, e.eol} || cyc != e.smp + 2)
          $display("FAIL pixel: got %h h=%0d v=%0d sof=%0b eol=%0b lat=%0d, want %h h=%0d v=%0d sof=%0b eol=%0b lat=2",
                   o_pixel, o_hpixel, o_vpixel, o_sof, o_eol, cyc - e.smp, e.pix, e.h, e.v, e.sof, e.eol);
        else
          passed++;
      end
    end
    if (rst_n && o_err) begin
      err_cnt++;
      last_err_cyc = cyc;
      err_eol = o_eol;
      err_h = o_hpixel;
    end
  end

  // Drive one input cycle; active pixels are recorded when the model says they are emitted.
  task automatic put(input logic hs, input logic vs, input logic d, input logic [23:0] rgb,
                     input logic [15:0] h, input logic [15:0] v, input logic eol);
    exp_t x;
    @(negedge clk);
    hsync = hs; vsync = vs; de = d;
    {blue, green, red} = rgb;
    if (vs) begin
      emit_model = 1'b1;
      last_vs_smp = cyc + 1;
    end
    if (d && emit_model && rst_n) begin
      x.pix = rgb; x.h = h; x.v = v; x.sof = (h == 0 && v == 0); x.eol = eol; x.smp = cyc + 1;
      sb.push_back(x);
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic blank_line();
    put(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    blank(HBP + W + HFP);
  endtask

  // VSYNC pulse followed by two back-porch lines.
  task automatic open_frame();
    put(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b0);
    blank(HBP + W + HFP);
    blank_line();
    blank_line();
    row_m = 0;
  endtask

  // One active line; viol_at >= 0 raises HSYNC on that pixel while DE is high.
  task automatic line(input int w, input int viol_at);
    logic [23:0] rgb;
    int          h;
    put(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    blank(HBP);
    for (int p = 0; p < w; p++) begin
      rgb = (force_first && p == 0 && row_m == 0) ? 24'h123456 : 24'($urandom);
      h = (viol_at >= 0 && p >= viol_at) ? p - viol_at : p;
      put(p == viol_at, 1'b0, 1'b1, rgb, 16'(h), 16'(row_m), p == w - 1);
    end
    blank(HFP);
    row_m++;
  endtask

  task automatic body(input int lines, input int short_at, input int viol_line);
    for (int l = 0; l < lines; l++)
      line((l == short_at) ? W - 1 : W, (l == viol_line) ? 4 : -1);
    blank_line();
  endtask

  task automatic test_reset();
    int v0, s0, e0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_pixel, o_valid, o_hpixel, o_vpixel, o_sof, o_eol, o_locked, o_err, o_line_len, o_frame_lines} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    else passed++;
    rst_n = 1'b1;
    // Partial line, reset asserted asynchronously while DE is high.
    put(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    blank(HBP);
    for (int p = 0; p < 3; p++) put(1'b0, 1'b0, 1'b1, 24'($urandom), 16'(p), '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_valid, o_locked, o_err, o_line_len, o_frame_lines} !== '0)
      $display("FAIL reset_midline: valid=%0b locked=%0b err=%0b, want 0", o_valid, o_locked, o_err);
    else passed++;
    for (int p = 3; p < 5; p++) put(1'b0, 1'b0, 1'b1, 24'($urandom), 16'(p), '0, 1'b0);
    rst_n = 1'b1;
    for (int p = 5; p < W; p++) put(1'b0, 1'b0, 1'b1, 24'($urandom), 16'(p), '0, 1'b0);
    blank(HFP);
    body(2, -1, -1);
    total++;
    if (valid_cnt != 0) $display("FAIL idle_no_valid: got %0d valid pixels, want 0", valid_cnt);
    else passed++;

    open_frame();
    v0 = valid_cnt; s0 = sof_cnt; e0 = eol_cnt;
    body(4, -1, -1);
    open_frame();
    total++;
    if (valid_cnt - v0 != 32 || sof_cnt - s0 != 1 || eol_cnt - e0 != 4)
      $display("FAIL frame1_counts: got valid=%0d sof=%0d eol=%0d, want 32/1/4", valid_cnt - v0, sof_cnt - s0, eol_cnt - e0);
    else passed++;
    total++;
    if ({o_locked, o_line_len, o_frame_lines} !== {1'b1, 16'd8, 16'd4})
      $display("FAIL lock_8x4: got locked=%0b len=%0d lines=%0d, want 1/8/4", o_locked, o_line_len, o_frame_lines);
    else passed++;
    body(4, -1, -1);
    open_frame();
    total++;
    if (o_locked !== 1'b1 || err_cnt != 0) $display("FAIL stay_locked: got locked=%0b errs=%0d, want 1/0", o_locked, err_cnt);
    else passed++;
  endtask

  task automatic test_pixel_pack();
    force_first = 1'b1;
    body(4, -1, -1);
    force_first = 1'b0;
    open_frame();
    total++;
    if (sof_pix !== 24'h123456) $display("FAIL pack: got %h, want 123456", sof_pix);
    else passed++;
    total++;
    if (sof_lat != 2) $display("FAIL pack_latency: got %0d edges, want 2", sof_lat);
    else passed++;
  endtask

  task automatic test_short_line();
    int e0;
    e0 = err_cnt;
    body(4, 2, -1);
    total++;
    if (err_cnt - e0 != 1 || err_eol !== 1'b1 || err_h !== 16'd6)
      $display("FAIL short_line_err: got errs=%0d eol=%0b h=%0d, want 1/1/6", err_cnt - e0, err_eol, err_h);
    else passed++;
    total++;
    if (o_locked !== 1'b0) $display("FAIL short_line_unlock: got locked=%0b, want 0", o_locked);
    else passed++;
    open_frame();
    total++;
    if (o_locked !== 1'b0) $display("FAIL bad_frame_no_lock: got locked=%0b, want 0", o_locked);
    else passed++;
    body(4, -1, -1);
    open_frame();
    total++;
    if (o_locked !== 1'b1 || err_cnt - e0 != 1)
      $display("FAIL short_line_relock: got locked=%0b errs=%0d, want 1/1", o_locked, err_cnt - e0);
    else passed++;
  endtask

  task automatic test_long_frame();
    int e0;
    e0 = err_cnt;
    body(5, -1, -1);
    open_frame();
    total++;
    if (err_cnt - e0 != 1 || last_err_cyc != last_vs_smp + 2)
      $display("FAIL long_frame_err: got errs=%0d at edge %0d, want 1 at edge %0d", err_cnt - e0, last_err_cyc, last_vs_smp + 2);
    else passed++;
    total++;
    if ({o_locked, o_line_len, o_frame_lines} !== {1'b0, 16'd8, 16'd4})
      $display("FAIL long_frame_hold: got locked=%0b len=%0d lines=%0d, want 0/8/4", o_locked, o_line_len, o_frame_lines);
    else passed++;
    body(4, -1, -1);
    open_frame();
    total++;
    if (o_locked !== 1'b1) $display("FAIL long_frame_relock: got locked=%0b, want 1", o_locked);
    else passed++;
  endtask

  task automatic test_hs_violation();
    int e0;
    e0 = err_cnt;
    body(4, -1, 1);
    total++;
    if (err_cnt - e0 != 1 || err_h !== 16'd0 || o_locked !== 1'b0)
      $display("FAIL hs_viol_locked: got errs=%0d h=%0d locked=%0b, want 1/0/0", err_cnt - e0, err_h, o_locked);
    else passed++;
    open_frame();
    e0 = err_cnt;
    body(4, -1, 1);
    total++;
    if (err_cnt != e0) $display("FAIL hs_viol_measure: got %0d errs, want 0", err_cnt - e0);
    else passed++;
    open_frame();
    total++;
    if (o_locked !== 1'b0) $display("FAIL hs_viol_no_lock: got locked=%0b, want 0", o_locked);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int v0, s0, e0, r0;
    v0 = valid_cnt; s0 = sof_cnt; e0 = eol_cnt; r0 = err_cnt;
    for (int l = 0; l < 6; l++) begin
      put(1'b0, 1'b0, 1'b1, 24'($urandom), '0, 16'(l), 1'b1);
      put(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    end
    blank(5);
    open_frame();
    total++;
    if (valid_cnt - v0 != 6 || sof_cnt - s0 != 1 || eol_cnt - e0 != 6 || err_cnt != r0)
      $display("FAIL b2b_counts: got valid=%0d sof=%0d eol=%0d err=%0d, want 6/1/6/0",
               valid_cnt - v0, sof_cnt - s0, eol_cnt - e0, err_cnt - r0);
    else passed++;
    total++;
    if ({o_locked, o_line_len, o_frame_lines} !== {1'b1, 16'd1, 16'd6})
      $display("FAIL b2b_lock: got locked=%0b len=%0d lines=%0d, want 1/1/6", o_locked, o_line_len, o_frame_lines);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_pixel_pack();
    test_short_line();
    test_long_frame();
    test_hs_violation();
    test_back_to_back();
    blank(10);
    total++;
    if (sb.size() != 0) $display("FAIL drain: got %0d pixels never output, want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
